fb_fill_master: RTL and testbench

Bus initiator that fills a contiguous run of frame-buffer bytes by writing through the VGA peripheral's register window on the shared 8-bit bus. It replaces the processor's per-byte software loop for clear-screen and solid or checkerboard rectangle-row fills. It sits on the same BUS_ADDR/BUS_DATA/BUS_WE bus as the processor and VGA peripheral. It gains bus ownership through a request/grant pair from the bus arbiter.

---
 rtl/fb_fill_master_if.sv | 11 +
 rtl/fb_fill_master.sv | 170 +++++++++++++++++
 tb/tb_fb_fill_master.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fb_fill_master_if.sv
// Shared-bus handshake and address/strobe signals seen by a bus initiator.
// The tristate data lines stay a plain inout on the initiator itself.
interface fb_fill_master_if;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (output BUS_REQ, output BUS_ADDR, output BUS_WE, input BUS_GNT);
  modport slave  (input BUS_REQ, input BUS_ADDR, input BUS_WE, output BUS_GNT);
endinterface

// File: rtl/fb_fill_master.sv
// Frame-buffer fill initiator: writes a run of bytes through the VGA register
// window (high addr, low addr, data) while holding the shared bus.
module fb_fill_master #(
  parameter logic [7:0] HIGH_ADDR_REG = 8'hB2,
  parameter logic [7:0] LOW_ADDR_REG  = 8'hB3,
  parameter logic [7:0] DATA_REG      = 8'hB4,
  parameter logic [7:0] IDLE_ADDR     = 8'hFF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [11:0]          FILL_BASE,
  input  logic [12:0]          FILL_LEN,
  input  logic [7:0]           FILL_DATA,
  input  logic                 CHECKER,
  output logic                 BUSY,
  output logic                 DONE,
  fb_fill_master_if.master     bus,
  inout  wire  [7:0]           BUS_DATA
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WR_HI   = 3'd2,
    S_WR_LO   = 3'd3,
    S_WR_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_cur;
  logic [12:0] r_rem;
  logic        r_odd;
  logic [7:0]  r_data;
  logic        r_chk;
  logic        r_zero_done;

  logic        w_req;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [7:0]  w_dout;
  logic        w_start_ok;
  logic        w_last;
  logic        w_cross;
  logic [7:0]  w_pattern;

  assign w_start_ok = (r_state == S_IDLE) && START;
  assign w_last     = (r_rem == 13'd1);
  // Incrementing past a 32-byte boundary changes cur[11:5], so the high register must be rewritten.
  assign w_cross    = (r_cur[4:0] == 5'd31);
  assign w_pattern  = (r_chk && r_odd) ? ~r_data : r_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START && (FILL_LEN != 13'd0)) w_next = S_REQ;
        else                              w_next = S_IDLE;
      end
      S_REQ: begin
        if (bus.BUS_GNT) w_next = S_WR_HI;
        else             w_next = S_REQ;
      end
      // A lost grant always resumes at WR_HI: another master may have moved the address registers.
      S_WR_HI: begin
        if (bus.BUS_GNT) w_next = S_WR_LO;
        else             w_next = S_WR_HI;
      end
      S_WR_LO: begin
        if (bus.BUS_GNT) w_next = S_WR_DATA;
        else             w_next = S_WR_HI;
      end
      S_WR_DATA: begin
        if (!bus.BUS_GNT) w_next = S_WR_HI;
        else if (w_last)  w_next = S_FIN;
        else if (w_cross) w_next = S_WR_HI;
        else              w_next = S_WR_LO;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cur       <= 12'd0;
      r_rem       <= 13'd0;
      r_odd       <= 1'b0;
      r_data      <= 8'd0;
      r_chk       <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_start_ok && (FILL_LEN == 13'd0);
      if (w_start_ok) begin
        r_cur  <= FILL_BASE;
        r_rem  <= FILL_LEN;
        r_odd  <= 1'b0;
        r_data <= FILL_DATA;
        r_chk  <= CHECKER;
      end else if ((r_state == S_WR_DATA) && bus.BUS_GNT) begin
        r_cur <= r_cur + 12'd1;
        r_rem <= r_rem - 13'd1;
        r_odd <= ~r_odd;
      end else begin
        r_cur <= r_cur;
        r_rem <= r_rem;
        r_odd <= r_odd;
      end
    end
  end

  always_comb begin
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_addr = IDLE_ADDR;
    w_dout = 8'h00;
    case (r_state)
      S_REQ: w_req = 1'b1;
      S_WR_HI: begin
        w_req = 1'b1;
        if (bus.BUS_GNT) begin
          w_we   = 1'b1;
          w_addr = HIGH_ADDR_REG;
          w_dout = {1'b0, r_cur[11:5]};
        end else begin
          w_we = 1'b0;
        end
      end
      S_WR_LO: begin
        w_req = 1'b1;
        if (bus.BUS_GNT) begin
          w_we   = 1'b1;
          w_addr = LOW_ADDR_REG;
          w_dout = {r_cur[4:0], 3'b000};
        end else begin
          w_we = 1'b0;
        end
      end
      S_WR_DATA: begin
        w_req = 1'b1;
        if (bus.BUS_GNT) begin
          w_we   = 1'b1;
          w_addr = DATA_REG;
          w_dout = w_pattern;
        end else begin
          w_we = 1'b0;
        end
      end
      default: w_req = 1'b0;
    endcase
  end

  assign bus.BUS_REQ  = w_req;
  assign bus.BUS_WE   = w_we;
  assign bus.BUS_ADDR = w_addr;
  assign BUS_DATA     = w_we ? w_dout : 8'hzz;
  assign BUSY         = (r_state != S_IDLE);
  assign DONE         = (r_state == S_FIN) || r_zero_done;

endmodule

// File: tb/tb_fb_fill_master.sv
// Scoreboard bench for fb_fill_master: expected bus writes are queued by the
// stimulus, a negedge monitor pops and compares them and models the frame RAM.
module tb_fb_fill_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] fill_base;
  logic [12:0] fill_len;
  logic [7:0]  fill_data;
  logic        checker_en;
  logic        busy;
  logic        done;
  wire  [7:0]  bus_data;

  fb_fill_master_if bus_if ();

  fb_fill_master dut (
    .CLK       (clk),
    .RESET     (reset),
    .START     (start),
    .FILL_BASE (fill_base),
    .FILL_LEN  (fill_len),
    .FILL_DATA (fill_data),
    .CHECKER   (checker_en),
    .BUSY      (busy),
    .DONE      (done),
    .bus       (bus_if),
    .BUS_DATA  (bus_data)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_data = 0;
  int          last_wr_cyc = 0;
  logic [15:0] exp_q[$];
  int          wcnt[4096];
  logic [7:0]  ram_hi = 8'h00;
  logic [7:0]  ram_lo = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write cycle is matched against the queue and applied to the RAM model.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus_if.BUS_WE === 1'b1) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: actual=%0h%0h expected=none", bus_if.BUS_ADDR, bus_data);
        end else begin
          e = exp_q.pop_front();
          chk("bus_write", {16'd0, bus_if.BUS_ADDR, bus_data}, {16'd0, e});
        end
        if (bus_if.BUS_ADDR == 8'hB2) ram_hi = bus_data;
        if (bus_if.BUS_ADDR == 8'hB3) ram_lo = bus_data;
        if (bus_if.BUS_ADDR == 8'hB4) begin
          n_data++;
          wcnt[{ram_hi[6:0], ram_lo[7:3]}]++;
        end
      end
    end
  end

  task automatic push_fill(input int base, input int len, input logic [7:0] d,
                           input logic chkr, input int gap_byte);
    logic [11:0] cur;
    for (int i = 0; i < len; i++) begin
      cur = 12'(base + i);
      if ((i == 0) || (cur[4:0] == 5'd0)) exp_q.push_back({8'hB2, 1'b0, cur[11:5]});
      exp_q.push_back({8'hB3, cur[4:0], 3'b000});
      if (i == gap_byte) begin
        exp_q.push_back({8'hB2, 1'b0, cur[11:5]});
        exp_q.push_back({8'hB3, cur[4:0], 3'b000});
      end
      exp_q.push_back({8'hB4, (chkr && i[0]) ? ~d : d});
    end
  endtask

  task automatic start_fill(input int base, input int len, input logic [7:0] d, input logic chkr);
    @(posedge clk); #1;
    start      = 1'b1;
    fill_base  = 12'(base);
    fill_len   = 13'(len);
    fill_data  = d;
    checker_en = chkr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int t;
    t = 0;
    while (t < max_cyc) begin
      @(negedge clk); #1;
      if (done === 1'b1) break;
      t++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_done_lat"}, cyc - last_wr_cyc, 32'd1);
    chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    chk({name, "_q_empty"}, exp_q.size(), 32'd0);
    @(negedge clk); #1;
    chk({name, "_done_fall"}, {31'd0, done}, 32'd0);
    chk({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_we"},   {31'd0, bus_if.BUS_WE}, 32'd0);
    chk({name, "_req"},  {31'd0, bus_if.BUS_REQ}, 32'd0);
    chk({name, "_addr"}, {24'd0, bus_if.BUS_ADDR}, 32'h0000_00FF);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int w0;
    int t;
    reset = 1'b1; start = 1'b0; fill_base = 12'd0; fill_len = 13'd0;
    fill_data = 8'd0; checker_en = 1'b0; bus_if.BUS_GNT = 1'b1;
    for (int i = 0; i < 4096; i++) wcnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Solid fill from address 0: single high write, then low/data pairs.
    exp_q.push_back(16'hB200); exp_q.push_back(16'hB300); exp_q.push_back(16'hB4AA);
    exp_q.push_back(16'hB308); exp_q.push_back(16'hB4AA); exp_q.push_back(16'hB310);
    exp_q.push_back(16'hB4AA); exp_q.push_back(16'hB318); exp_q.push_back(16'hB4AA);
    w0 = n_wr;
    start_fill(0, 4, 8'hAA, 1'b0);
    wait_done("solid4", 40);
    chk("solid4_nwr", n_wr - w0, 32'd9);

    // Checkerboard across a 32-byte boundary.
    exp_q.push_back(16'hB200); exp_q.push_back(16'hB3F0); exp_q.push_back(16'hB40F);
    exp_q.push_back(16'hB3F8); exp_q.push_back(16'hB4F0); exp_q.push_back(16'hB201);
    exp_q.push_back(16'hB300); exp_q.push_back(16'hB40F); exp_q.push_back(16'hB308);
    exp_q.push_back(16'hB4F0);
    start_fill(30, 4, 8'h0F, 1'b1);
    wait_done("checker", 40);

    // Zero length: DONE one cycle after START, no request.
    w0 = n_wr;
    start_fill(0, 0, 8'h55, 1'b0);
    #9;
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_req", {31'd0, bus_if.BUS_REQ}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk_idle("len0_after");
    end
    chk("len0_nwr", n_wr - w0, 32'd0);

    // Grant loss during the data write of byte 2 of an 8-byte fill.
    for (int i = 0; i < 4096; i++) wcnt[i] = 0;
    push_fill(0, 8, 8'h5A, 1'b0, 2);
    w0 = n_wr;
    start_fill(0, 8, 8'h5A, 1'b0);
    t = 0;
    while ((n_wr - w0 < 6) && (t < 50)) begin
      @(negedge clk); #1;
      t++;
    end
    chk("gap_reach", {31'd0, (n_wr - w0 >= 6)}, 32'd1);
    @(posedge clk); #1 bus_if.BUS_GNT = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("gap_we", {31'd0, bus_if.BUS_WE}, 32'd0);
      chk("gap_req", {31'd0, bus_if.BUS_REQ}, 32'd1);
    end
    @(posedge clk); #1 bus_if.BUS_GNT = 1'b1;
    wait_done("gap", 60);
    for (int i = 0; i < 8; i++) chk($sformatf("gap_wcnt%0d", i), wcnt[i], 32'd1);

    // Reset in the middle of a long fill.
    push_fill(0, 100, 8'h33, 1'b0, -1);
    w0 = n_data;
    start_fill(0, 100, 8'h33, 1'b0);
    t = 0;
    while ((n_data - w0 < 5) && (t < 50)) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_reach", {31'd0, (n_data - w0 >= 5)}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("midrst");
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    // Address wrap 4095 -> 0; a START while busy must not disturb the fill.
    exp_q.push_back(16'hB27F); exp_q.push_back(16'hB3F0); exp_q.push_back(16'hB43C);
    exp_q.push_back(16'hB3F8); exp_q.push_back(16'hB43C); exp_q.push_back(16'hB200);
    exp_q.push_back(16'hB300); exp_q.push_back(16'hB43C);
    start_fill(4094, 3, 8'h3C, 1'b0);
    @(posedge clk); #1;
    start_fill(100, 50, 8'h00, 1'b1);
    wait_done("wrap", 40);
    repeat (5) @(negedge clk);
    chk_idle("wrap_after");
    chk("wrap_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
